// File: rtl/router_pkg.sv
// Shared router flit format: flit width, flit-type encodings and the FLIT_t payload.
package router_pkg;

  localparam int unsigned FLIT_SIZE   = 32;
  localparam int unsigned FLIT_DATA_W = FLIT_SIZE - 3;

  localparam logic [1:0] HEAD_FLIT = 2'd1;
  localparam logic [1:0] BODY_FLIT = 2'd2;
  localparam logic [1:0] TAIL_FLIT = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic [1:0]             flit_type;
    logic [FLIT_DATA_W-1:0] data;
  } FLIT_t;

endpackage

// File: rtl/tg_link_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one router input link among
// NUM_SRC traffic generators, gated by downstream credits.
module tg_link_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned PKT_FLITS = 4,
  parameter int unsigned CREDITS   = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_SRC-1:0]                  i_req,
  input  logic [NUM_SRC-1:0][FLIT_SIZE-1:0]   i_flit,
  input  logic                                i_credit_return,
  output logic [NUM_SRC-1:0]                  o_send,
  output logic [FLIT_SIZE-1:0]                o_flit,
  output logic                                o_flit_valid,
  output logic [$clog2(NUM_SRC)-1:0]          o_grant_id,
  output logic                                o_busy,
  output logic [$clog2(CREDITS):0]            o_credits,
  output logic                                o_error
);

  localparam int unsigned GID_W  = $clog2(NUM_SRC);
  localparam int unsigned CRED_W = $clog2(CREDITS) + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [GID_W-1:0]     ptr_q, ptr_d;
  logic [GID_W-1:0]     gid_q, gid_d;
  logic [CRED_W-1:0]    cred_q, cred_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [NUM_SRC-1:0]   send_q, send_d;
  logic [FLIT_SIZE-1:0] flit_q, flit_d;
  logic                 fvalid_q, fvalid_d;
  logic                 err_q, err_d;

  FLIT_t                cur_flit;
  logic                 credit_ok;
  logic                 fwd;
  logic                 is_tail;
  logic                 tmo_hit;
  logic                 rr_found;
  logic [GID_W-1:0]     rr_winner;
  int unsigned          rr_idx;

  // Only the granted source's flit is ever looked at.
  assign cur_flit  = i_flit[gid_q];
  assign credit_ok = (cred_q >= CRED_W'(PKT_FLITS));
  assign fwd       = (state_q == ST_XFER) && cur_flit.valid;
  assign is_tail   = fwd && (cur_flit.flit_type == TAIL_FLIT);
  assign tmo_hit   = (state_q == ST_XFER) && !cur_flit.valid
                     && (tmo_q == TMO_W'(TIMEOUT - 1));

  // Round-robin search starting one past the last served source.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = 0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      rr_idx = (32'(ptr_q) + i) % NUM_SRC;
      if (!rr_found && i_req[GID_W'(rr_idx)]) begin
        rr_found  = 1'b1;
        rr_winner = GID_W'(rr_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rr_found && credit_ok) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_XFER;
      ST_XFER:  if (is_tail || tmo_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    tmo_d    = tmo_q;
    send_d   = '0;
    flit_d   = flit_q;
    fvalid_d = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_found && credit_ok) gid_d = rr_winner;
      end
      ST_GRANT: begin
        send_d = NUM_SRC'(1) << gid_q;
        tmo_d  = '0;
      end
      ST_XFER: begin
        if (fwd) begin
          flit_d   = cur_flit;
          fvalid_d = 1'b1;
          tmo_d    = '0;
          if (is_tail) ptr_d = gid_q;
        end else if (tmo_hit) begin
          err_d = 1'b1;
          ptr_d = gid_q;
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase

    // A return and a forward in the same cycle cancel out.
    if (i_credit_return && fwd) begin
      cred_d = cred_q;
    end else if (i_credit_return && (cred_q < CRED_W'(CREDITS))) begin
      cred_d = cred_q + CRED_W'(1);
    end else if (fwd && (cred_q != '0)) begin
      cred_d = cred_q - CRED_W'(1);
    end else begin
      cred_d = cred_q;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= GID_W'(NUM_SRC - 1);
      gid_q    <= '0;
      cred_q   <= CRED_W'(CREDITS);
      tmo_q    <= '0;
      send_q   <= '0;
      flit_q   <= '0;
      fvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      cred_q   <= cred_d;
      tmo_q    <= tmo_d;
      send_q   <= send_d;
      flit_q   <= flit_d;
      fvalid_q <= fvalid_d;
      err_q    <= err_d;
    end
  end

  assign o_send       = send_q;
  assign o_flit       = flit_q;
  assign o_flit_valid = fvalid_q;
  assign o_grant_id   = gid_q;
  assign o_credits    = cred_q;
  assign o_error      = err_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tg_link_arbiter.sv
// Scoreboard bench for tg_link_arbiter: directed packets, credits, timeout, reset.
module tb_tg_link_arbiter;
  import router_pkg::*;

  localparam int unsigned N = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N-1:0]                i_req;
  logic [N-1:0][FLIT_SIZE-1:0] i_flit;
  logic                        i_credit_return;
  logic [N-1:0]                o_send;
  logic [FLIT_SIZE-1:0]        o_flit;
  logic                        o_flit_valid;
  logic [1:0]                  o_grant_id;
  logic                        o_busy;
  logic [3:0]                  o_credits;
  logic                        o_error;

  tg_link_arbiter #(.NUM_SRC(4), .PKT_FLITS(4), .CREDITS(8), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_req           (i_req),
    .i_flit          (i_flit),
    .i_credit_return (i_credit_return),
    .o_send          (o_send),
    .o_flit          (o_flit),
    .o_flit_valid    (o_flit_valid),
    .o_grant_id      (o_grant_id),
    .o_busy          (o_busy),
    .o_credits       (o_credits),
    .o_error         (o_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int exp_cred = 8;
  int pkt_id   = 0;
  int exp_grant_q[$];
  logic [FLIT_SIZE-1:0] exp_flit_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected grants and flits whenever the DUT presents them.
  int           mon_e;
  logic [N-1:0] mon_ev;
  logic [FLIT_SIZE-1:0] mon_f;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (o_send != '0) begin
        if (exp_grant_q.size() == 0) begin
          chk("unexpected_send", 64'(o_send), 64'(0));
        end else begin
          mon_e  = exp_grant_q.pop_front();
          mon_ev = '0;
          mon_ev[2'(mon_e)] = 1'b1;
          chk("send_vec", 64'(o_send), 64'(mon_ev));
          chk("grant_id", 64'(o_grant_id), 64'(mon_e));
        end
      end
      if (o_flit_valid) begin
        if (exp_flit_q.size() == 0) begin
          chk("unexpected_flit", 64'(o_flit_valid), 64'(0));
        end else begin
          mon_f = exp_flit_q.pop_front();
          chk("flit", 64'(o_flit), 64'(mon_f));
        end
      end
      if (o_error) err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mkflit(input int src, input int k, input int nfl, output logic [FLIT_SIZE-1:0] v);
    FLIT_t f;
    f.valid     = 1'b1;
    f.flit_type = (k == 0) ? HEAD_FLIT : ((k == nfl - 1) ? TAIL_FLIT : BODY_FLIT);
    f.data      = FLIT_DATA_W'((pkt_id << 8) | (src << 4) | k);
    v = f;
  endtask

  task automatic wait_send(input int src, output int lat);
    exp_grant_q.push_back(src);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (o_send != '0) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk("send_wait", 64'(o_send != '0), 64'(1));
  endtask

  // Drives a packet from src; an unselected neighbour drives a valid tail flit as noise.
  task automatic send_flits(input int src, input int nfl, input bit ret);
    logic [FLIT_SIZE-1:0] v;
    FLIT_t junk;
    int nz;
    nz = (src + 1) % N;
    junk.valid = 1'b1;
    junk.flit_type = TAIL_FLIT;
    junk.data = FLIT_DATA_W'(32'h1ABCD);
    for (int k = 0; k < 4; k++) begin
      if (k < nfl) begin
        mkflit(src, k, 4, v);
        i_flit = '0;
        i_flit[2'(src)] = v;
        i_flit[2'(nz)]  = junk;
        i_credit_return = ret;
        exp_flit_q.push_back(v);
        tick();
        if (!ret) exp_cred--;
        chk("credits_xfer", 64'(o_credits), 64'(exp_cred));
      end
    end
    i_flit = '0;
    i_credit_return = 1'b0;
    pkt_id++;
  endtask

  task automatic ret_pulse();
    i_credit_return = 1'b1;
    tick();
    i_credit_return = 1'b0;
    if (exp_cred < 8) exp_cred++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    reset = 1'b1;
    i_req = '0;
    i_flit = '0;
    i_credit_return = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send",    64'(o_send), 64'(0));
    chk("rst_flit",    64'(o_flit), 64'(0));
    chk("rst_fvalid",  64'(o_flit_valid), 64'(0));
    chk("rst_gid",     64'(o_grant_id), 64'(0));
    chk("rst_busy",    64'(o_busy), 64'(0));
    chk("rst_error",   64'(o_error), 64'(0));
    chk("rst_credits", 64'(o_credits), 64'(8));
    reset = 1'b0;
    tick();

    // Single request from source 0.
    i_req = 4'b0001;
    wait_send(0, lat);
    i_req = '0;
    chk("single_latency", 64'(lat), 64'(1));
    chk("busy_in_xfer", 64'(o_busy), 64'(1));
    send_flits(0, 4, 1'b0);
    chk("single_busy_after", 64'(o_busy), 64'(0));
    chk("single_credits", 64'(o_credits), 64'(4));

    // Credit gating: drain to 0, refill to 3 (no grant), then 4 (grant).
    i_req = 4'b0001;
    wait_send(0, lat);
    send_flits(0, 4, 1'b0);
    repeat (3) ret_pulse();
    repeat (4) tick();
    chk("gate_busy", 64'(o_busy), 64'(0));
    chk("gate_credits3", 64'(o_credits), 64'(3));
    ret_pulse();
    chk("gate_credits4", 64'(o_credits), 64'(4));
    wait_send(0, lat);
    i_req = '0;
    chk("gate_latency", 64'(lat), 64'(1));
    send_flits(0, 4, 1'b0);
    repeat (9) ret_pulse();
    chk("credits_saturate", 64'(o_credits), 64'(8));

    // Timeout: source 1 sends a head only.
    i_req = 4'b1111;
    wait_send(1, lat);
    send_flits(1, 1, 1'b0);
    cnt = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_error) begin
        cnt = c;
        break;
      end
    end
    chk("timeout_cycles", 64'(cnt), 64'(16));
    chk("timeout_idle", 64'(o_busy), 64'(0));
    wait_send(2, lat);
    i_req = '0;
    chk("after_timeout_latency", 64'(lat), 64'(1));
    send_flits(2, 4, 1'b1);
    chk("err_once", 64'(err_seen), 64'(1));

    // Reset in the middle of a packet from source 3.
    i_req = 4'b1111;
    wait_send(3, lat);
    send_flits(3, 2, 1'b0);
    reset = 1'b1;
    void'(exp_flit_q.pop_back());
    #1;
    exp_cred = 8;
    chk("mid_rst_send",    64'(o_send), 64'(0));
    chk("mid_rst_fvalid",  64'(o_flit_valid), 64'(0));
    chk("mid_rst_flit",    64'(o_flit), 64'(0));
    chk("mid_rst_busy",    64'(o_busy), 64'(0));
    chk("mid_rst_gid",     64'(o_grant_id), 64'(0));
    chk("mid_rst_credits", 64'(o_credits), 64'(8));
    tick();
    tick();
    reset = 1'b0;

    // Round robin from reset with returns coinciding with every forwarded flit.
    for (int p = 0; p < 5; p++) begin
      wait_send(p % 4, lat);
      send_flits(p % 4, 4, 1'b1);
    end
    i_req = '0;
    repeat (3) tick();
    chk("rr_busy", 64'(o_busy), 64'(0));
    chk("rr_credits", 64'(o_credits), 64'(8));
    chk("grant_q_empty", 64'(exp_grant_q.size()), 64'(0));
    chk("flit_q_empty", 64'(exp_flit_q.size()), 64'(0));
    chk("err_total", 64'(err_seen), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
